// File: rtl/segments_display_ctrl_if.sv
// Avalon-MM slave register port for the seven-segment controller.
// Zero-wait: readdata is combinational from address and writes have no backpressure.
interface segments_display_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/segments_display_ctrl.sv
// Seven-segment controller: hex/raw digits with per-digit enable and blink, via Avalon-MM registers.
// Writes land on the edge and show on out_port one edge later; there is no backpressure.
module segments_display_ctrl #(
    parameter int          NUM_DIGITS = 3,
    parameter int          ACTIVE_LOW = 1,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                      clk,
    input  logic                      reset,
    segments_display_ctrl_if.slave    bus,
    output logic [7*NUM_DIGITS-1:0]   out_port
);

    localparam int N = NUM_DIGITS;
    localparam logic [31:0]  CNT_LAST = 32'(BLINK_DIV - 1);
    localparam logic [7*N-1:0] BLANK  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*N-1:0] hex_q;
    logic [7*N-1:0] raw_q;
    logic           mode_q;
    logic [N-1:0]   en_q;
    logic [N-1:0]   mask_q;
    logic [31:0]    cnt_q;
    logic           phase_q;

    logic           wr;
    logic           wr_ctrl;
    logic [7*N-1:0] pat;
    logic [7*N-1:0] out_d;

    // Only the low register-width bits of writedata are stored.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_ctrl = wr && (bus.address == 2'd2);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q  <= '0;
            raw_q  <= '0;
            mode_q <= 1'b0;
            en_q   <= '1;
            mask_q <= '0;
        end else begin
            if (wr && bus.address == 2'd0) hex_q <= bus.writedata[4*N-1:0];
            if (wr && bus.address == 2'd1) raw_q <= bus.writedata[7*N-1:0];
            if (wr_ctrl) begin
                mode_q <= bus.writedata[0];
                en_q   <= bus.writedata[8 +: N];
                mask_q <= bus.writedata[16 +: N];
            end
        end
    end

    // A CTRL write with bit 31 set overrides a coincident wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (wr_ctrl && bus.writedata[31]) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        pat = '0;
        for (int k = 0; k < N; k++) begin
            if (en_q[k] && !(mask_q[k] && phase_q)) begin
                pat[7*k +: 7] = mode_q ? raw_q[7*k +: 7] : hex7(hex_q[4*k +: 4]);
            end
        end
        out_d = (ACTIVE_LOW != 0) ? ~pat : pat;
    end

    always_ff @(posedge clk) begin
        if (reset) out_port <= BLANK;
        else       out_port <= out_d;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata[4*N-1:0] = hex_q;
            2'd1: bus.readdata[7*N-1:0] = raw_q;
            2'd2: begin
                bus.readdata[0]      = mode_q;
                bus.readdata[8 +: N]  = en_q;
                bus.readdata[16 +: N] = mask_q;
            end
            default: bus.readdata[0] = phase_q;
        endcase
    end

endmodule

// File: tb/tb_segments_display_ctrl.sv
// Directed bench for segments_display_ctrl with N=3, active-low outputs and a short blink period.
module tb_segments_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] out_port;

    segments_display_ctrl_if bus();

    segments_display_ctrl #(
        .NUM_DIGITS (3),
        .ACTIVE_LOW (1),
        .BLINK_DIV  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic [20:0] exp_out;
    } vec_t;

    vec_t vecs [11];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Phase must stay 0 for three edges after a counter restart, then toggle.
    task automatic phase_run(input string tag);
        bus.address = 2'd3;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            #1;
            check(tag, {31'd0, bus.readdata[0]}, (j == 4) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h0000_00A5, 2'd0, 32'h0000_00A5, 21'h100412};
        vecs[1]  = '{2'd1, 32'h001F_FFFF, 2'd1, 32'h001F_FFFF, 21'h100412};
        vecs[2]  = '{2'd2, 32'h0000_0701, 2'd2, 32'h0000_0701, 21'h000000};
        vecs[3]  = '{2'd2, 32'h0000_0501, 2'd2, 32'h0000_0501, 21'h003F80};
        vecs[4]  = '{2'd3, 32'hFFFF_FFFF, 2'd2, 32'h0000_0501, 21'h003F80};
        vecs[5]  = '{2'd2, 32'h0000_0600, 2'd2, 32'h0000_0600, 21'h10047F};
        vecs[6]  = '{2'd0, 32'hFFFF_F123, 2'd0, 32'h0000_0123, 21'h1E527F};
        vecs[7]  = '{2'd2, 32'h8000_F8FE, 2'd2, 32'h0000_0000, 21'h1FFFFF};
        vecs[8]  = '{2'd2, 32'h0000_0700, 2'd2, 32'h0000_0700, 21'h1E5230};
        vecs[9]  = '{2'd1, 32'h1234_5678, 2'd1, 32'h0014_5678, 21'h1E5230};
        vecs[10] = '{2'd2, 32'h0000_0301, 2'd2, 32'h0000_0301, 21'h1FE987};

        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_out", {11'd0, out_port}, 32'h001F_FFFF);
        bus.address = 2'd0; #1; check("reset_hex",    bus.readdata, 32'h0);
        bus.address = 2'd1; #1; check("reset_raw",    bus.readdata, 32'h0);
        bus.address = 2'd2; #1; check("reset_ctrl",   bus.readdata, 32'h0000_0700);
        bus.address = 2'd3; #1; check("reset_status", bus.readdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("post_reset_zeros", {11'd0, out_port}, 32'h0010_2040);

        // Table of single-register writes
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            @(negedge clk);
            bus.address = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), {11'd0, out_port}, {11'd0, vecs[i].exp_out});
        end

        // Blink digit 0, starting from a synchronised counter
        wr(2'd1, 32'h001F_FFFF);
        wr(2'd2, 32'h8001_0701);
        bus.address = 2'd3;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("blink%0d_phase", i), {31'd0, bus.readdata[0]}, ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("blink%0d_out", i), {11'd0, out_port}, (((i - 1) / 4) % 2 == 1) ? 32'h7F : 32'h0);
        end

        // Clear landing on the exact wrap edge
        wr(2'd2, 32'h8001_0701);
        @(negedge clk);
        @(negedge clk);
        wr(2'd2, 32'h8001_0701);
        bus.address = 2'd3; #1; check("wrapclr_phase", bus.readdata, 32'h0);
        bus.address = 2'd2; #1; check("wrapclr_ctrl",  bus.readdata, 32'h0001_0701);
        phase_run("wrapclr_restart");

        // Reset beats a concurrent HEX write and restarts blinking
        @(negedge clk);
        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0000_0FFF;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        #1;
        check("rstwr_hex", bus.readdata, 32'h0);
        check("rstwr_out", {11'd0, out_port}, 32'h001F_FFFF);
        phase_run("rst_restart");
        #1;
        check("rst_after_out", {11'd0, out_port}, 32'h0010_2040);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
